// File: rtl/pingpong_shift_ctrl.sv
// pingpong_shift_ctrl: sequences two-bank (ping-pong) ownership for a writer and a reader
// and emits the one-cycle toggle pulses that steer the address-set stage shift enablers.
// Latency: wr_ack/rd_ack are combinational; addresses, flags and pulses update on the accepting edge.
// Backpressure: the writer stalls while its bank is full, and the reader stalls while its bank is empty.
//
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   flush             synchronous realign/clear; overrides every accept
//   wr_req / wr_ack   producer handshake, wr_addr = {wrt_bank, wr_off}
//   rd_req / rd_ack   consumer handshake, rd_addr = {rd_bank, rd_off}
//   chng_wrt_shft     registered toggle pulse for the write-side enabler
//   chng_rd_shft      registered toggle pulse for the read-side enabler
//   wrt_bank, rd_bank mirrors of the address-set stage enablers
//   bank_full, level  per-bank full flags and their population count
module pingpong_shift_ctrl #(
  parameter int DEPTH_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr_req,
  output logic               wr_ack,
  output logic [DEPTH_W:0]   wr_addr,
  input  logic               rd_req,
  output logic               rd_ack,
  output logic [DEPTH_W:0]   rd_addr,
  output logic               chng_wrt_shft,
  output logic               chng_rd_shft,
  output logic               wrt_bank,
  output logic               rd_bank,
  output logic [1:0]         bank_full,
  output logic [1:0]         level
);

  localparam logic [DEPTH_W-1:0] LAST_OFF = '1;

  // Both FSMs are pure decodes of the full flags; no separate state register exists.
  typedef enum logic {W_FILL, W_WAIT} w_state_t;
  typedef enum logic {R_WAIT, R_DRAIN} r_state_t;

  logic [DEPTH_W-1:0] r_wr_off;
  logic [DEPTH_W-1:0] r_rd_off;
  logic               r_wrt_bank;
  logic               r_rd_bank;
  logic [1:0]         r_bank_full;
  logic               r_chng_wrt;
  logic               r_chng_rd;

  w_state_t           w_wr_state;
  r_state_t           w_rd_state;
  logic               w_wr_last;
  logic               w_rd_last;
  logic [1:0]         w_full_nxt;

  assign w_wr_state = r_bank_full[r_wrt_bank] ? W_WAIT : W_FILL;
  assign w_rd_state = r_bank_full[r_rd_bank]  ? R_DRAIN : R_WAIT;

  assign wr_ack = wr_req & ~flush & (w_wr_state == W_FILL);
  assign rd_ack = rd_req & ~flush & (w_rd_state == R_DRAIN);

  assign w_wr_last = wr_ack & (r_wr_off == LAST_OFF);
  assign w_rd_last = rd_ack & (r_rd_off == LAST_OFF);

  // Set and clear never hit the same bit in one cycle: a write needs the
  // bank empty, a read needs it full.
  always_comb begin
    w_full_nxt = r_bank_full;
    if (w_wr_last) w_full_nxt[r_wrt_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank]  = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_off    <= '0;
      r_rd_off    <= '0;
      r_wrt_bank  <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      r_chng_wrt  <= 1'b0;
      r_chng_rd   <= 1'b0;
    end else if (flush) begin
      r_wr_off    <= '0;
      r_rd_off    <= '0;
      r_wrt_bank  <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_bank_full <= 2'b00;
      // A pointer that was 1 needs one toggle to bring its enabler back to 0.
      r_chng_wrt  <= r_wrt_bank;
      r_chng_rd   <= r_rd_bank;
    end else begin
      r_chng_wrt  <= 1'b0;
      r_chng_rd   <= 1'b0;
      r_bank_full <= w_full_nxt;
      if (wr_ack) begin
        if (w_wr_last) begin
          r_wr_off   <= '0;
          r_wrt_bank <= ~r_wrt_bank;
          r_chng_wrt <= 1'b1;
        end else begin
          r_wr_off   <= r_wr_off + 1'b1;
        end
      end
      if (rd_ack) begin
        if (w_rd_last) begin
          r_rd_off  <= '0;
          r_rd_bank <= ~r_rd_bank;
          r_chng_rd <= 1'b1;
        end else begin
          r_rd_off  <= r_rd_off + 1'b1;
        end
      end
    end
  end

  assign wr_addr       = {r_wrt_bank, r_wr_off};
  assign rd_addr       = {r_rd_bank, r_rd_off};
  assign chng_wrt_shft = r_chng_wrt;
  assign chng_rd_shft  = r_chng_rd;
  assign wrt_bank      = r_wrt_bank;
  assign rd_bank       = r_rd_bank;
  assign bank_full     = r_bank_full;
  assign level         = {1'b0, r_bank_full[0]} + {1'b0, r_bank_full[1]};

endmodule
